// File: rtl/updown_modcnt_hex.sv
// Up/down modulo-N counter with wrap/saturate, parallel load, terminal-count pulse
// and an active-low seven-segment hex readout of the count register.

module updown_modcnt_hex_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Segment order {g,f,e,d,c,b,a}, active low.
  always_comb begin
    seg = 7'b1000000;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end
endmodule

module updown_modcnt_hex #(
  parameter  int MODULUS   = 6,
  parameter  int W         = 3,
  parameter  int EDGE_MODE = 0,
  localparam int N_DIGITS  = (W + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [W-1:0]          load_val,
  input  logic                  sat,
  output logic [W-1:0]          count,
  output logic                  tc,
  output logic [7*N_DIGITS-1:0] HEX
);
  // Upper limit kept in W bits so MODULUS = 2**W never overflows.
  localparam logic [W-1:0] MAX = W'(MODULUS - 1);

  logic         step;
  logic [W-1:0] count_next;
  logic         tc_next;

  generate
    if (EDGE_MODE == 1) begin : g_edge
      // Reset to 1 so a key held through reset cannot fake a rising edge.
      logic s0, s1, s2;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s0 <= 1'b1;
          s1 <= 1'b1;
          s2 <= 1'b1;
        end else begin
          s0 <= en;
          s1 <= s0;
          s2 <= s1;
        end
      end
      assign step = s1 & ~s2;
    end else begin : g_level
      assign step = en;
    end
  endgenerate

  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    casez ({load, step, dir})
      3'b1??: count_next = (load_val > MAX) ? MAX : load_val;
      3'b010: begin
        if (count < MAX) count_next = count + W'(1);
        else begin
          count_next = sat ? MAX : '0;
          tc_next    = 1'b1;
        end
      end
      3'b011: begin
        if (count != '0) count_next = count - W'(1);
        else begin
          count_next = sat ? '0 : MAX;
          tc_next    = 1'b1;
        end
      end
      3'b00?: count_next = count;
      default: count_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= tc_next;
    end
  end

  // Zero-extend the count to whole nibbles for the top digit.
  logic [4*N_DIGITS-1:0] count_pad;
  always_comb begin
    count_pad          = '0;
    count_pad[W-1:0]   = count;
  end

  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
      updown_modcnt_hex_seg u_dig (
        .nib (count_pad[4*k +: 4]),
        .seg (HEX[7*k +: 7])
      );
    end
  endgenerate
endmodule

// File: tb/tb_updown_modcnt_hex.sv
// Directed bench for updown_modcnt_hex: three instances (level mode, key mode,
// mod-200 wide counter) checked through an expected-value queue.

module tb_updown_modcnt_hex;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en0 = 0, dir0 = 0, load0 = 0, sat0 = 0;
  logic [2:0] lv0 = '0, cnt0;
  logic       tc0;
  logic [6:0] hex0;

  logic       en1 = 0, dir1 = 0, load1 = 0, sat1 = 0;
  logic [2:0] lv1 = '0, cnt1;
  logic       tc1;
  logic [6:0] hex1;

  logic       en2 = 0, dir2 = 0, load2 = 0, sat2 = 0;
  logic [7:0] lv2 = '0, cnt2;
  logic       tc2;
  logic [13:0] hex2;

  updown_modcnt_hex dut0 (
    .clk(clk), .rst(rst), .en(en0), .dir(dir0), .load(load0), .load_val(lv0),
    .sat(sat0), .count(cnt0), .tc(tc0), .HEX(hex0));

  updown_modcnt_hex #(.EDGE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .dir(dir1), .load(load1), .load_val(lv1),
    .sat(sat1), .count(cnt1), .tc(tc1), .HEX(hex1));

  updown_modcnt_hex #(.MODULUS(200), .W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .dir(dir2), .load(load2), .load_val(lv2),
    .sat(sat2), .count(cnt2), .tc(tc2), .HEX(hex2));

  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic       tc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic push(input int id, input logic [7:0] c, input logic t, input string tag);
    exp_t e;
    e.id = id; e.cnt = c; e.tc = t; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0]  ac;
    logic        at;
    logic [13:0] ah, eh;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin ac = {5'b0, cnt0}; at = tc0; ah = {7'b0, hex0}; eh = {7'b0, seg(e.cnt[3:0])}; end
        1:       begin ac = {5'b0, cnt1}; at = tc1; ah = {7'b0, hex1}; eh = {7'b0, seg(e.cnt[3:0])}; end
        default: begin ac = cnt2; at = tc2; ah = hex2; eh = {seg(e.cnt[7:4]), seg(e.cnt[3:0])}; end
      endcase
      checks++;
      assert (ac === e.cnt) else begin
        errors++;
        $error("FAIL %s count got %0d want %0d", e.tag, ac, e.cnt);
      end
      checks++;
      assert (at === e.tc) else begin
        errors++;
        $error("FAIL %s tc got %0b want %0b", e.tag, at, e.tc);
      end
      checks++;
      assert (ah === eh) else begin
        errors++;
        $error("FAIL %s hex got %b want %b", e.tag, ah, eh);
      end
    end
  endtask

  initial begin
    // Reset state, no clock edge required.
    #2;
    push(0, 0, 0, "rst0"); push(1, 0, 0, "rst1"); push(2, 0, 0, "rst2");
    drain();
    @(negedge clk) rst = 1'b1;
    tick();

    // Level-mode wrap up through 5 -> 0.
    en0 = 1;
    for (int i = 1; i <= 7; i++) begin
      push(0, 8'(i % 6), (i == 6), $sformatf("up_wrap%0d", i));
      tick(); drain();
    end
    en0 = 0;

    // Down from 0: wrap, then saturate.
    load0 = 1; lv0 = 0; push(0, 0, 0, "ld0"); tick(); drain();
    load0 = 0; en0 = 1; dir0 = 1; push(0, 5, 1, "dn_wrap"); tick(); drain();
    en0 = 0; push(0, 5, 0, "dn_wrap_hold"); tick(); drain();
    load0 = 1; lv0 = 0; push(0, 0, 0, "ld0b"); tick(); drain();
    load0 = 0; sat0 = 1; en0 = 1; push(0, 0, 1, "dn_sat1"); tick(); drain();
    push(0, 0, 1, "dn_sat2"); tick(); drain();
    en0 = 0; push(0, 0, 0, "dn_sat_idle"); tick(); drain();
    load0 = 1; lv0 = 5; push(0, 5, 0, "ld5"); tick(); drain();
    load0 = 0; dir0 = 0; en0 = 1; push(0, 5, 1, "up_sat"); tick(); drain();
    en0 = 0; sat0 = 0;

    // Load beats a coincident step; out-of-range loads clamp.
    load0 = 1; en0 = 1; lv0 = 4; push(0, 4, 0, "ld4_step"); tick(); drain();
    lv0 = 7; push(0, 5, 0, "ld7_clamp"); tick(); drain();
    lv0 = 6; push(0, 5, 0, "ld6_clamp"); tick(); drain();
    load0 = 0; en0 = 0;

    // Asynchronous reset mid-count.
    load0 = 1; lv0 = 3; push(0, 3, 0, "ld3"); tick(); drain();
    load0 = 0;
    #3 rst = 1'b0;
    #1 push(0, 0, 0, "rst_async"); drain();
    #10;
    @(negedge clk) rst = 1'b1;
    en0 = 1; push(0, 1, 0, "first_after_rst"); tick(); drain();
    en0 = 0;
    repeat (4) tick();

    // Key mode: one step per press, at the third edge.
    en1 = 1;
    for (int i = 1; i <= 10; i++) begin
      push(1, (i >= 3) ? 8'd1 : 8'd0, 0, $sformatf("key_hold%0d", i));
      tick(); drain();
    end
    en1 = 0;
    for (int i = 1; i <= 2; i++) begin
      push(1, 1, 0, $sformatf("key_low%0d", i)); tick(); drain();
    end
    en1 = 1;
    for (int i = 1; i <= 4; i++) begin
      push(1, (i >= 3) ? 8'd2 : 8'd1, 0, $sformatf("key_again%0d", i));
      tick(); drain();
    end
    en1 = 0;

    // Mod-200, two hex digits.
    load2 = 1; lv2 = 8'hB7; push(2, 8'hB7, 0, "w_ldB7"); tick(); drain();
    checks++;
    assert (hex2 === 14'b0000011_1111000) else begin
      errors++;
      $error("FAIL w_hexB7 got %b want %b", hex2, 14'b0000011_1111000);
    end
    lv2 = 8'hFF; push(2, 199, 0, "w_ldFF_clamp"); tick(); drain();
    lv2 = 198; push(2, 198, 0, "w_ld198"); tick(); drain();
    load2 = 0; en2 = 1; push(2, 199, 0, "w_up199"); tick(); drain();
    push(2, 0, 1, "w_wrap"); tick(); drain();
    en2 = 0; push(2, 0, 0, "w_idle"); tick(); drain();
    dir2 = 1; en2 = 1; push(2, 199, 1, "w_dn_wrap"); tick(); drain();
    en2 = 0; push(2, 199, 0, "w_dn_idle"); tick(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
